// File: rtl/modulo_display_bcd_3_digitos.sv
// 7-bit binary to 3-digit BCD with multiplexed common-anode 7-seg scan.
// Define DISPLAY_BLANK_ZEROS_EN to blank leading zero digits.
`timescale 1ns/1ps
module modulo_display_bcd_3_digitos #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [6:0]  valor,
  output logic [11:0] bcd,
  output logic        conv_done,
  output logic [6:0]  seg,
  output logic [2:0]  dig
);

  typedef enum logic [1:0] {
    LOAD,
    SHIFT,
    DONE
  } state_t;

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

  state_t      state;
  logic [6:0]  sr;
  logic [11:0] scr;
  logic [11:0] adj;
  logic [2:0]  nsh;

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic [1:0]    idx_nxt;
  logic          tc;
  logic [3:0]    nib;
  logic [6:0]    seg_nxt;
  logic [2:0]    dig_nxt;
  logic          blank;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  function automatic logic [6:0] dec(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  assign adj = {add3(scr[11:8]), add3(scr[7:4]), add3(scr[3:0])};

  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= LOAD;
      sr        <= '0;
      scr       <= '0;
      nsh       <= '0;
      bcd       <= '0;
      conv_done <= 1'b0;
    end else begin
      conv_done <= 1'b0;
      case (state)
        LOAD: begin
          sr    <= valor;
          scr   <= '0;
          nsh   <= '0;
          state <= SHIFT;
        end
        SHIFT: begin
          {scr, sr} <= {adj[10:0], sr, 1'b0};
          nsh       <= nsh + 3'd1;
          if (nsh == 3'd6) state <= DONE;
        end
        DONE: begin
          bcd       <= scr;
          conv_done <= 1'b1;
          state     <= LOAD;
        end
        default: state <= LOAD;
      endcase
    end
  end

  // Digit select and segments are both derived from the next index.
  assign tc = (cnt == CW'(REFRESH_DIV - 1));

  always_comb begin
    idx_nxt = idx;
    if (tc) idx_nxt = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  end

  always_comb begin
    nib     = bcd[3:0];
    dig_nxt = 3'b110;
    blank   = 1'b0;
    unique case (idx_nxt)
      2'd1: begin
        nib     = bcd[7:4];
        dig_nxt = 3'b101;
`ifdef DISPLAY_BLANK_ZEROS_EN
        blank   = (bcd[11:8] == 4'd0) && (bcd[7:4] == 4'd0);
`endif
      end
      2'd2: begin
        nib     = bcd[11:8];
        dig_nxt = 3'b011;
`ifdef DISPLAY_BLANK_ZEROS_EN
        blank   = (bcd[11:8] == 4'd0);
`endif
      end
      default: begin
        nib     = bcd[3:0];
        dig_nxt = 3'b110;
      end
    endcase
    seg_nxt = blank ? 7'h7F : dec(nib);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt <= '0;
      idx <= 2'd0;
      dig <= 3'b110;
      seg <= 7'h40;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      idx <= idx_nxt;
      dig <= dig_nxt;
      seg <= seg_nxt;
    end
  end

endmodule

// File: tb/tb_modulo_display_bcd_3_digitos.sv
// Bench for modulo_display_bcd_3_digitos: directed and random stimulus
// against a cycle-level decimal/scan reference model.
`timescale 1ns/1ps
module tb_modulo_display_bcd_3_digitos;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic [6:0]  valor = '0;
  logic [11:0] bcd;
  logic        conv_done;
  logic [6:0]  seg;
  logic [2:0]  dig;

  modulo_display_bcd_3_digitos #(.REFRESH_DIV(DIV)) dut (
    .clk       (clk),
    .clr       (clr),
    .valor     (valor),
    .bcd       (bcd),
    .conv_done (conv_done),
    .seg       (seg),
    .dig       (dig)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  int          t = 0;
  logic [6:0]  sampled = '0;
  logic [11:0] m_bcd = '0;
  logic        m_done = 1'b0;
  logic [6:0]  m_seg = 7'h40;
  logic [2:0]  m_dig = 3'b110;

  logic [6:0] seg_tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  function automatic logic [11:0] to_bcd(input int v);
    return 12'((v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10));
  endfunction

  function automatic logic [6:0] seg_of(input logic [11:0] b, input int i);
    logic [3:0] d;
    d = (i == 0) ? b[3:0] : (i == 1) ? b[7:4] : b[11:8];
`ifdef DISPLAY_BLANK_ZEROS_EN
    if (i == 2 && b[11:8] == 4'd0) return 7'h7F;
    if (i == 1 && b[11:8] == 4'd0 && b[7:4] == 4'd0) return 7'h7F;
`endif
    return seg_tbl[d];
  endfunction

  task automatic check(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    end
  endtask

  // One clock; reference model advances by decimal arithmetic and a
  // 9-cycle conversion period counted from the release of clr.
  task automatic step();
    logic [11:0] old;
    int i;
    if (!clr && ((t + 1) % 9 == 1)) sampled = valor;
    @(posedge clk);
    #1;
    if (clr) begin
      t = 0;
      m_bcd = '0;
      m_done = 1'b0;
      m_seg = 7'h40;
      m_dig = 3'b110;
    end else begin
      t++;
      old = m_bcd;
      i = (t / DIV) % 3;
      m_dig = ~(3'b001 << i);
      m_seg = seg_of(old, i);
      m_done = (t % 9 == 0);
      if (m_done) m_bcd = to_bcd(int'(sampled));
    end
    check("bcd", bcd, m_bcd);
    check("conv_done", 12'(conv_done), 12'(m_done));
    check("dig", 12'(dig), 12'(m_dig));
    check("seg", 12'(seg), 12'(m_seg));
  endtask

  task automatic align_scan();
    for (int i = 0; i < 3 * DIV && (t % (3 * DIV)) != 0; i++) step();
  endtask

  initial begin
    // Reset with a pending value
    clr = 1'b1;
    valor = 7'd99;
    step();
    step();
    check("rst_bcd", bcd, 12'h000);
    check("rst_dig", 12'(dig), 12'(3'b110));
    check("rst_seg", 12'(seg), 12'(7'h40));
    clr = 1'b0;
    repeat (9) step();
    check("first_conv_bcd", bcd, 12'h099);
    check("first_conv_done", 12'(conv_done), 12'd1);

    // Value change two cycles into a conversion
    for (int i = 0; i < 9 && (t % 9) != 0; i++) step();
    valor = 7'd42;
    step();
    step();
    step();
    valor = 7'd77;
    repeat (6) step();
    check("mid_first", bcd, 12'h042);
    repeat (9) step();
    check("mid_next", bcd, 12'h077);

    // Scan order with 108
    valor = 7'd108;
    repeat (18) step();
    align_scan();
    check("scan_dig0", 12'(dig), 12'(3'b110));
    check("scan_seg0", 12'(seg), 12'(7'h00));
    repeat (DIV) step();
    check("scan_dig1", 12'(dig), 12'(3'b101));
    check("scan_seg1", 12'(seg), 12'(7'h40));
    repeat (DIV) step();
    check("scan_dig2", 12'(dig), 12'(3'b011));
    check("scan_seg2", 12'(seg), 12'(7'h79));

    // Leading zeros with 5
    valor = 7'd5;
    repeat (18) step();
    align_scan();
    check("blank_seg0", 12'(seg), 12'(7'h12));
    repeat (DIV) step();
`ifdef DISPLAY_BLANK_ZEROS_EN
    check("blank_seg1", 12'(seg), 12'(7'h7F));
`else
    check("blank_seg1", 12'(seg), 12'(7'h40));
`endif
    repeat (DIV) step();
`ifdef DISPLAY_BLANK_ZEROS_EN
    check("blank_seg2", 12'(seg), 12'(7'h7F));
`else
    check("blank_seg2", 12'(seg), 12'(7'h40));
`endif

    // Full range sweep
    for (int v = 0; v < 128; v++) begin
      valor = 7'(v);
      repeat (18) step();
      check("sweep", bcd, to_bcd(v));
    end

    // clr in the middle of a 127 conversion
    valor = 7'd127;
    for (int i = 0; i < 9 && (t % 9) != 1; i++) step();
    repeat (3) step();
    clr = 1'b1;
    step();
    check("clr_mid_bcd", bcd, 12'h000);
    clr = 1'b0;
    repeat (8) step();
    check("clr_mid_nodone", 12'(conv_done), 12'd0);
    step();
    check("clr_mid_next", bcd, 12'h127);

    // Random values, hold times and occasional clr
    for (int k = 0; k < 300; k++) begin
      valor = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 15) == 0) begin
        clr = 1'b1;
        step();
        clr = 1'b0;
      end
      repeat ($urandom_range(1, 20)) step();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/modulo_display_bcd_3_digitos.md
# modulo_display_bcd_3_digitos

Downstream display stage for the 7-bit synchronous up counter: takes its 7-bit count `q` (0–127) and shows it in decimal on three multiplexed common-anode 7-segment digits. A free-running sequential shift-and-add-3 (double-dabble) converter turns the sampled binary value into three BCD digits. A refresh divider then scans the digits one at a time. All outputs are registered.

## Interface
- `REFRESH_DIV`, default 50000: clock cycles each digit stays selected; legal range ≥ 1.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `clr`  in  1  reset, synchronous, active-high; priority over every other input.
- `valor`  in  7  binary value to display (the counter's `q`).
- `bcd`  out  12  last completed conversion: [11:8] hundreds, [7:4] tens, [3:0] units.
- `conv_done`  out  1  one-cycle pulse in the cycle `bcd` is updated.
- `seg`  out  7  active-low segments, `seg[0]`=a … `seg[6]`=g.
- `dig`  out  3  active-low digit select: `dig[0]` units, `dig[1]` tens, `dig[2]` hundreds.

## Operation
- Converter FSM, three states, loops forever:
  - LOAD: sample `valor` into shift reg; clear BCD scratch; go to SHIFT.
  - SHIFT: 7 cycles; each cycle, first add 3 to every scratch nibble ≥ 5, then shift {scratch, shift reg} left 1. After the 7th shift, go to DONE.
  - DONE: copy scratch to `bcd`; assert `conv_done`; go to LOAD.
- Period is exactly 9 cycles. `valor` is read only in LOAD; changes during SHIFT/DONE appear in the next conversion.
- Max value 127 gives `bcd`=12'h127. The hundreds nibble never exceeds 1. No overflow path.
- Scanner:
  - Refresh counter runs 0..REFRESH_DIV-1. At terminal count it wraps to 0 and the digit index advances 0→1→2→0.
  - With REFRESH_DIV=1, the index advances every cycle.
- Decode from current `bcd` nibble, active-low {g..a}: 0:7'h40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78, 8:00, 9:10. Codes 10–15 cannot occur; map them to 7'h7F.
- `seg` and `dig` are registered and change together on the same edge. Exactly one `dig` bit is low at all times after reset.
- Reset values:
  - FSM in LOAD, counters 0, index 0.
  - `bcd`=12'h000, `conv_done`=0.
  - `dig`=3'b110, `seg`=7'h40.
- `clr` mid-conversion: aborts the conversion, discards the scratch contents and applies the reset values on that edge. A new conversion starts on the first cycle after `clr` deasserts.

## Timing
- `valor` sampled at edge N (LOAD) → `bcd` valid and `conv_done`=1 after edge N+8. The next LOAD is at edge N+9.
- Worst case from a `valor` change to a new `bcd`: 17 cycles.
- A new `bcd` reaches `seg` at the next scanner update that selects that digit. This takes at most 3·REFRESH_DIV cycles, plus 1 cycle for the output register.
- After `clr` deasserts:
  - First `conv_done` comes 9 cycles later.
  - First digit advance comes REFRESH_DIV cycles later.

## Configuration
- `DISPLAY_BLANK_ZEROS_EN` defined: leading-zero blanking.
  - Hundreds digit shows 7'h7F when hundreds==0.
  - Tens digit shows 7'h7F when hundreds==0 and tens==0.
  - Units digit is never blanked. `dig` scanning is unchanged.
- Not defined: all three digits always decoded, e.g. 5 displays "005".
- `bcd` and `conv_done` are identical in both builds.

## Test plan
- Reset: assert `clr` 2 cycles with `valor`=7'd99 → `bcd`=000, `conv_done`=0, `dig`=110, `seg`=7'h40. After release, first `conv_done` on the 9th cycle with `bcd`=12'h099.
- Full range: sweep `valor` 0..127, holding each value ≥ 18 cycles → `bcd` equals the decimal of each value. Endpoints: 0→000, 127→127. `conv_done` period is exactly 9 cycles.
- Mid-conversion change: `valor`=42 sampled, change to 77 two cycles later → first `bcd`=12'h042, next `bcd`=12'h077.
- Scan with REFRESH_DIV=4, `valor`=108:
  - `dig` sequence is 110,101,011, each held 4 cycles.
  - `seg` sequence is 7'h00, 7'h40, 7'h79.
- Blanking, `valor`=5: with `DISPLAY_BLANK_ZEROS_EN`, `seg` is 12, 7F, 7F per digit. Without it, `seg` is 12, 40, 40.
- `clr` during SHIFT (`valor`=127, 4 cycles after LOAD) → `bcd` stays 000 and no `conv_done` that period. The next conversion yields 12'h127.
